nx_msg_arbiter: RTL and testbench

Arbitrates REQUESTERS independent message streams onto the single outbound host link, alongside the top-level controller's response stream. Port 0 is the strict-priority port (controller responses). Ports 1..REQUESTERS-1 (mesh output, debug) are served round-robin. Multi-message packets are held atomic via a per-port last flag, and a starvation limit bounds how long port 0 can monopolise the link. The output is fully registered, one message per cycle at full throughput.

---
 rtl/nx_msg_arbiter.sv | 163 ++++++++++++++++
 tb/tb_nx_msg_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nx_msg_arbiter.sv
// Host-link message arbiter: port 0 has strict priority bounded by a starvation limit,
// ports 1..REQUESTERS-1 share round-robin, packets stay atomic via the per-port last flag.
module nx_msg_arbiter #(
  parameter int unsigned REQUESTERS   = 4,
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [REQUESTERS*WIDTH-1:0]   req_data_i,
  input  logic [REQUESTERS-1:0]         req_last_i,
  input  logic [REQUESTERS-1:0]         req_valid_i,
  output logic [REQUESTERS-1:0]         req_ready_o,
  output logic [WIDTH-1:0]              arb_data_o,
  output logic                          arb_last_o,
  output logic [$clog2(REQUESTERS)-1:0] arb_source_o,
  output logic                          arb_valid_o,
  input  logic                          arb_ready_i
);

  localparam int unsigned IdxW = $clog2(REQUESTERS);
  localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] lock_id_q, lock_id_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [StW-1:0]  starve_q, starve_d;

  logic [WIDTH-1:0] out_data_q;
  logic             out_last_q;
  logic [IdxW-1:0]  out_src_q;
  logic             out_valid_q;

  logic             others_valid;
  logic             load;
  logic             rr_found;
  logic [IdxW-1:0]  rr_idx;
  logic [IdxW-1:0]  grant;
  logic             accept;
  logic             acc_last;
  logic [WIDTH-1:0] acc_data;

  assign others_valid = |req_valid_i[REQUESTERS-1:1];
  assign load         = !out_valid_q || arb_ready_i;

  // Cyclic search over ports 1..REQUESTERS-1 starting just after the last served port.
  always_comb begin
    int unsigned start;
    int unsigned cand;
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = 0;
    if (rr_ptr_q == '0 || 32'(rr_ptr_q) >= REQUESTERS - 1) begin
      start = 1;
    end else begin
      start = 32'(rr_ptr_q) + 1;
    end
    for (int unsigned k = 0; k < REQUESTERS - 1; k++) begin
      cand = start + k;
      if (cand > REQUESTERS - 1) begin
        cand = cand - (REQUESTERS - 1);
      end
      if (!rr_found && req_valid_i[IdxW'(cand)]) begin
        rr_found = 1'b1;
        rr_idx   = IdxW'(cand);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (state_q == StLocked) begin
      grant = lock_id_q;
    end else if (req_valid_i[0] && (starve_q < StW'(STARVE_LIMIT) || !others_valid)) begin
      grant = '0;
    end else if (rr_found) begin
      grant = rr_idx;
    end
  end

  assign accept   = rstn_i && load && req_valid_i[grant];
  assign acc_last = req_last_i[grant];
  assign acc_data = req_data_i[32'(grant)*WIDTH +: WIDTH];

  always_comb begin
    req_ready_o = '0;
    if (accept) begin
      req_ready_o[grant] = 1'b1;
    end
  end

  // Rotation pointer and starvation count only move on the first message of a packet.
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    starve_d  = starve_q;
    if (accept) begin
      case (state_q)
        StIdle: begin
          if (!acc_last) begin
            state_d   = StLocked;
            lock_id_d = grant;
          end
          if (grant == '0) begin
            if (!others_valid) begin
              starve_d = '0;
            end else if (starve_q < StW'(STARVE_LIMIT)) begin
              starve_d = starve_q + 1'b1;
            end
          end else begin
            rr_ptr_d = grant;
            starve_d = '0;
          end
        end
        StLocked: begin
          if (acc_last) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= StIdle;
      lock_id_q <= '0;
      rr_ptr_q  <= '0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      rr_ptr_q  <= rr_ptr_d;
      starve_q  <= starve_d;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
    end else if (load) begin
      out_valid_q <= accept;
      if (accept) begin
        out_data_q <= acc_data;
        out_last_q <= acc_last;
        out_src_q  <= grant;
      end
    end
  end

  assign arb_data_o   = out_data_q;
  assign arb_last_o   = out_last_q;
  assign arb_source_o = out_src_q;
  assign arb_valid_o  = out_valid_q;

endmodule

// File: tb/tb_nx_msg_arbiter.sv
// Scoreboard bench for nx_msg_arbiter: directed traffic pushes expected messages,
// a forked monitor pops and compares on every output transfer.
module tb_nx_msg_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SL = 8;

  logic           clk = 1'b0;
  logic           rstn;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   arb_data;
  logic           arb_last;
  logic [1:0]     arb_source;
  logic           arb_valid;
  logic           arb_ready;

  nx_msg_arbiter #(
    .REQUESTERS  (N),
    .WIDTH       (W),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .arb_data_o  (arb_data),
    .arb_last_o  (arb_last),
    .arb_source_o(arb_source),
    .arb_valid_o (arb_valid),
    .arb_ready_i (arb_ready)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]  src;
    logic        last;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned xfer_cyc[$];
  int          checks   = 0;
  int          failures = 0;
  logic [W-1:0] base [N];
  int unsigned  cnt [N];
  int unsigned  pkt_len [N];
  logic [N-1:0] rdy;

  function automatic void chk(input string name, input logic [63:0] got,
                              input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endfunction

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      req_data[p*W +: W] = base[p] + cnt[p];
      req_last[p]        = ((cnt[p] + 1) % pkt_len[p]) == 0;
    end
  endtask

  // Sample ready before the edge, then advance each port's message index if it was taken.
  task automatic tick();
    @(negedge clk);
    rdy = req_ready;
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++) begin
      if (rdy[p]) cnt[p]++;
    end
    drive();
  endtask

  task automatic push(input int src, input logic last, input logic [31:0] data);
    exp_t e;
    e.src  = 2'(src);
    e.last = last;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && arb_valid && arb_ready) begin
        xfer_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mon_unexpected: got src=%0d data=%h, expected no transfer",
                   arb_source, arb_data);
        end else begin
          e = exp_q.pop_front();
          chk("mon_xfer", {29'b0, arb_source, arb_last, arb_data},
              {29'b0, e.src, e.last, e.data});
        end
      end
    end
  endtask

  task automatic init_ports();
    for (int p = 0; p < N; p++) begin
      cnt[p]     = 0;
      pkt_len[p] = 1;
      base[p]    = 32'hA000_0000 + (32'(p) << 24);
    end
    drive();
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    req_valid = '0;
    arb_ready = 1'b1;
    init_ports();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic finish_test(input string nm);
    req_valid = '0;
    repeat (3) tick();
    chk({nm, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic span_chk(input string nm, input int n0, input int want_n,
                          input int want_span);
    chk({nm, "_count"}, 64'(xfer_cyc.size() - n0), 64'(want_n));
    if (xfer_cyc.size() > n0) begin
      chk({nm, "_span"}, 64'(xfer_cyc[xfer_cyc.size()-1] - xfer_cyc[n0]), 64'(want_span));
    end
  endtask

  initial begin
    int n0;
    rstn      = 1'b0;
    arb_ready = 1'b1;
    init_ports();
    req_valid = 4'hF;
    fork
      monitor();
    join_none

    // Reset state, with every port requesting
    @(posedge clk);
    #1;
    chk("rst_ready",  64'(req_ready), 64'h0);
    chk("rst_valid",  64'(arb_valid), 64'h0);
    chk("rst_data",   64'(arb_data), 64'h0);
    chk("rst_last",   64'(arb_last), 64'h0);
    chk("rst_source", 64'(arb_source), 64'h0);
    do_reset();

    // Single message from port 2
    base[2]      = 32'hDEAD_BEEF;
    drive();
    req_valid[2] = 1'b1;
    push(2, 1'b1, 32'hDEAD_BEEF);
    tick();
    chk("single_ready", 64'(rdy), 64'h4);
    req_valid = '0;
    tick();
    chk("single_ready_off", 64'(rdy), 64'h0);
    finish_test("single");

    // Round-robin among ports 1..3
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int p = 1; p < 4; p++) push(p, 1'b1, 32'hA000_0000 + (32'(p) << 24) + 32'(r));
    end
    n0        = xfer_cyc.size();
    req_valid = 4'b1110;
    tick();
    chk("rr_first_ready", 64'(rdy), 64'h2);
    repeat (5) tick();
    finish_test("rr");
    span_chk("rr", n0, 6, 5);

    // Starvation bound: 8 port-0 packets then one port-3 packet
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 8; k++) push(0, 1'b1, 32'hA000_0000 + 32'(r*8 + k));
      push(3, 1'b1, 32'hA300_0000 + 32'(r));
    end
    n0        = xfer_cyc.size();
    req_valid = 4'b1001;
    repeat (18) tick();
    finish_test("starve");
    span_chk("starve", n0, 18, 17);

    // Packet atomicity: port 1 holds the link through a gap, port 0 waits
    do_reset();
    pkt_len[1] = 4;
    drive();
    for (int k = 0; k < 4; k++) push(1, k == 3, 32'hA100_0000 + 32'(k));
    push(0, 1'b1, 32'hA000_0000);
    n0        = xfer_cyc.size();
    req_valid = 4'b0010;
    tick();
    chk("pkt_ready1", 64'(rdy), 64'h2);
    req_valid = 4'b0011;
    tick();
    chk("pkt_ready2", 64'(rdy), 64'h2);
    req_valid = 4'b0001;
    tick();
    chk("pkt_gap1", 64'(rdy), 64'h0);
    tick();
    chk("pkt_gap2", 64'(rdy), 64'h0);
    req_valid = 4'b0011;
    tick();
    chk("pkt_ready3", 64'(rdy), 64'h2);
    tick();
    chk("pkt_ready4", 64'(rdy), 64'h2);
    req_valid = 4'b0001;
    tick();
    chk("pkt_port0", 64'(rdy), 64'h1);
    finish_test("pkt");
    span_chk("pkt", n0, 5, 6);

    // Backpressure: slot full, downstream stalled for 5 cycles
    do_reset();
    push(0, 1'b1, 32'hA000_0000);
    push(0, 1'b1, 32'hA000_0001);
    req_valid = 4'hF;
    tick();
    chk("bp_first", 64'(rdy), 64'h1);
    arb_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_ready", 64'(rdy), 64'h0);
      chk("bp_hold", {29'b0, arb_source, arb_last, arb_data}, {29'b0, 2'd0, 1'b1, 32'hA000_0000});
    end
    arb_ready = 1'b1;
    tick();
    chk("bp_refill", 64'(rdy), 64'h1);
    finish_test("bp");

    // Asynchronous reset in the middle of a locked packet
    do_reset();
    pkt_len[1] = 4;
    drive();
    push(1, 1'b0, 32'hA100_0000);
    push(0, 1'b1, 32'hA000_0000);
    req_valid = 4'b0010;
    tick();
    tick();
    #1;
    rstn = 1'b0;
    #1;
    chk("arst_valid", 64'(arb_valid), 64'h0);
    chk("arst_ready", 64'(req_ready), 64'h0);
    req_valid = 4'b0011;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
    chk("arst_port0", 64'(rdy), 64'h1);
    finish_test("arst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
